aes128_encrypt_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 71 +++++++
 rtl/aes_key_step.sv | 21 ++
 rtl/aes128_encrypt_iter.sv | 103 ++++++++++
 tb/tb_aes128_encrypt_iter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the encrypt and decrypt datapaths.
// Byte 0 of a block sits at bit 127; columns are groups of four consecutive bytes.
package aes_pkg;

  typedef logic [0:15][7:0] aes_state_t;
  typedef logic [0:3][31:0] aes_cols_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} aes_fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 key schedule step: one round key to the next.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]) ^ rcon_i, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Define AES_LAST_KEY_OUT_EN to expose the round-10 key on last_key.
module aes128_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_LAST_KEY_OUT_EN
  output logic [127:0] ciphertext,
  output logic [127:0] last_key
`else
  output logic [127:0] ciphertext
`endif
);

  aes_fsm_e   fsm_q, fsm_d;
  aes_state_t state_q, state_d;
  logic [127:0] key_q, key_d, rk_next;
  logic [3:0]   round_q, round_d;

  aes_state_t sb, sr;
  aes_cols_t  sr_cols, mc_cols;

  aes_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (rcon(round_q)),
    .key_o  (rk_next)
  );

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      sb[4'(i)] = sbox(state_q[4'(i)]);
    end
    // ShiftRows: row r of column c takes row r of column (c + r) mod 4
    sr = {sb[0],  sb[5],  sb[10], sb[15],
          sb[4],  sb[9],  sb[14], sb[3],
          sb[8],  sb[13], sb[2],  sb[7],
          sb[12], sb[1],  sb[6],  sb[11]};
    sr_cols = sr;
    for (int unsigned c = 0; c < 4; c++) begin
      mc_cols[2'(c)] = mix_column(sr_cols[2'(c)]);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = plaintext ^ key;
          key_d   = key;
          round_d = 4'd1;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        key_d = rk_next;
        if (round_q == LAST_ROUND) begin
          state_d = sr ^ rk_next;
          fsm_d   = S_DONE;
        end else begin
          state_d = mc_cols ^ rk_next;
          round_d = round_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign in_ready   = (fsm_q == S_IDLE);
  assign out_valid  = (fsm_q == S_DONE);
  assign ciphertext = state_q;
`ifdef AES_LAST_KEY_OUT_EN
  assign last_key   = key_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed-vector bench for aes128_encrypt_iter (FIPS-197 App. B and C.1).
module tb_aes128_encrypt_iter;

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_LK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] plaintext, key, ciphertext, last_key;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_encrypt_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef AES_LAST_KEY_OUT_EN
    .ciphertext (ciphertext),
    .last_key   (last_key)
`else
    .ciphertext (ciphertext)
`endif
  );

`ifndef AES_LAST_KEY_OUT_EN
  assign last_key = '0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_last(input string tag, input logic [127:0] exp);
`ifdef AES_LAST_KEY_OUT_EN
    check(tag, last_key, exp);
`endif
  endtask

  // Present a block from a negedge; returns on the negedge after the accept edge.
  task automatic send(input logic [127:0] p, input logic [127:0] k);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 128'd0, 128'd1);
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int unsigned n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_timeout", 128'd0, 128'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, t1, t2;
    logic got1, got2;
    logic [127:0] ct1, ct2, lk2;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    check_last("rst_last_key", 128'd0);
    rst = 1'b0;
    @(negedge clk);

    send(B_PT, B_KEY);
    wait_out(lat);
    check("B_latency", 128'(lat), 128'd10);
    check("B_ct", ciphertext, B_CT);
    check_last("B_last_key", B_LK);
    take();

    send(C_PT, C_KEY);
    wait_out(lat);
    check("C1_latency", 128'(lat), 128'd10);
    check("C1_ct", ciphertext, C_CT);
    check_last("C1_last_key", C_LK);
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      plaintext = {4{$urandom}};
      key       = {4{$urandom}};
      @(negedge clk);
      check("bp_ct", ciphertext, C_CT);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
    end
    check_last("bp_last_key", C_LK);
    in_valid = 1'b0;
    take();
    check("post_bp_in_ready", 128'(in_ready), 128'd1);
    check("post_bp_out_valid", 128'(out_valid), 128'd0);

    // Back-to-back: in_valid held high, second block swapped in right after first accept.
    got1 = 1'b0; got2 = 1'b0; t1 = 0; t2 = 0; ct1 = '0; ct2 = '0; lk2 = '0;
    plaintext = B_PT; key = B_KEY; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    plaintext = C_PT; key = C_KEY;
    for (int n = 0; n < 40; n++) begin
      if (cyc == acc_cyc + 12) in_valid = 1'b0;
      if (out_valid) begin
        if (!got1) begin
          got1 = 1'b1; t1 = cyc; ct1 = ciphertext;
        end else if (!got2) begin
          got2 = 1'b1; t2 = cyc; ct2 = ciphertext; lk2 = last_key;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_got_both", 128'({got1, got2}), 128'd3);
    check("b2b_lat1", 128'(t1 - acc_cyc), 128'd10);
    check("b2b_ct1", ct1, B_CT);
    check("b2b_ct2", ct2, C_CT);
    check("b2b_gap", 128'(t2 - t1), 128'd12);
`ifdef AES_LAST_KEY_OUT_EN
    check("b2b_last_key2", lk2, C_LK);
`endif
    check("b2b_idle_after", 128'({in_ready, out_valid}), 128'd2);

    // Reset lands on the edge that would have executed round 5.
    send(B_PT, B_KEY);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_ct", ciphertext, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    send(B_PT, B_KEY);
    wait_out(lat);
    check("midrst_rerun_lat", 128'(lat), 128'd10);
    check("midrst_rerun_ct", ciphertext, B_CT);
    take();

    send(C_PT, C_KEY);
    plaintext = B_PT;
    key       = B_KEY;
    wait_out(lat);
    check("chg_ct", ciphertext, C_CT);
    check_last("chg_last_key", C_LK);
    take();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
